// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared encodings and BCD field layout for the alarm mode controller
package alarm_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_ADJ_TIME  = 2'd1,
        MODE_ADJ_ALARM = 2'd2,
        MODE_RINGING   = 2'd3
    } mode_t;

    // Internal state adds SNOOZE_CALC, which reports as CLOCK on the mode output.
    typedef enum logic [2:0] {
        ST_CLOCK,
        ST_ADJ_TIME,
        ST_ADJ_ALARM,
        ST_RINGING,
        ST_SNOOZE_CALC
    } state_t;

    typedef enum logic {
        FIELD_HOURS = 1'b0,
        FIELD_MINS  = 1'b1
    } field_t;

    localparam int HM_W   = 13;
    localparam int SEC_W  = 7;
    localparam int TIME_W = HM_W + SEC_W;
    localparam int HM_LSB = SEC_W;
    localparam int HT_OFS = 11;
    localparam int HU_OFS = 7;
    localparam int MT_OFS = 4;

    function automatic mode_t state_mode(state_t s);
        case (s)
            ST_ADJ_TIME:  return MODE_ADJ_TIME;
            ST_ADJ_ALARM: return MODE_ADJ_ALARM;
            ST_RINGING:   return MODE_RINGING;
            default:      return MODE_CLOCK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_hm_step.sv
// rtl/bcd_hm_step.sv - combinational +/-1 step of one field of a BCD HH:MM value
// carry_en lets a minute wrap ripple into the hour field (used for snooze arithmetic).
module bcd_hm_step
    import alarm_pkg::*;
(
    input  logic [HM_W-1:0] hm,
    input  field_t          field,
    input  logic            up,
    input  logic            carry_en,
    output logic [HM_W-1:0] hm_next
);

    logic [1:0] ht, ht_n;
    logic [3:0] hu, hu_n;
    logic [2:0] mt, mt_n;
    logic [3:0] mu, mu_n;
    logic       step_hours;

    assign ht = hm[HT_OFS +: 2];
    assign hu = hm[HU_OFS +: 4];
    assign mt = hm[MT_OFS +: 3];
    assign mu = hm[3:0];

    always_comb begin
        ht_n       = ht;
        hu_n       = hu;
        mt_n       = mt;
        mu_n       = mu;
        step_hours = (field == FIELD_HOURS);
        if (field == FIELD_MINS) begin
            if (up) begin
                if (mu == 4'd9) begin
                    mu_n = 4'd0;
                    if (mt == 3'd5) begin
                        mt_n       = 3'd0;
                        step_hours = carry_en;
                    end else begin
                        mt_n = mt + 3'd1;
                    end
                end else begin
                    mu_n = mu + 4'd1;
                end
            end else begin
                if (mu == 4'd0) begin
                    mu_n = 4'd9;
                    if (mt == 3'd0) begin
                        mt_n       = 3'd5;
                        step_hours = carry_en;
                    end else begin
                        mt_n = mt - 3'd1;
                    end
                end else begin
                    mu_n = mu - 4'd1;
                end
            end
        end
        if (step_hours) begin
            if (up) begin
                if (ht == 2'd2 && hu == 4'd3) begin
                    ht_n = 2'd0;
                    hu_n = 4'd0;
                end else if (hu == 4'd9) begin
                    ht_n = ht + 2'd1;
                    hu_n = 4'd0;
                end else begin
                    hu_n = hu + 4'd1;
                end
            end else begin
                if (ht == 2'd0 && hu == 4'd0) begin
                    ht_n = 2'd2;
                    hu_n = 4'd3;
                end else if (hu == 4'd0) begin
                    ht_n = ht - 2'd1;
                    hu_n = 4'd9;
                end else begin
                    hu_n = hu - 4'd1;
                end
            end
        end
    end

    assign hm_next = {ht_n, hu_n, mt_n, mu_n};

endmodule

// File: rtl/alarm_mode_ctrl.sv
// rtl/alarm_mode_ctrl.sv - alarm clock mode FSM, alarm registers, match trigger and ringer
// Optional snooze support is built when SNOOZE_EN is defined.
module alarm_mode_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_MIN   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              btn_c,
    input  logic              btn_u,
    input  logic              btn_d,
    input  logic              btn_l,
    input  logic              btn_r,
    input  logic              alarm_arm,
    input  logic [TIME_W-1:0] time_bcd,
    output logic              time_en,
    output logic              c_up_min,
    output logic              c_up_hour,
    output logic              c_down_min,
    output logic              c_down_hour,
    output logic [HM_W-1:0]   alarm_bcd,
    output logic              disp_alarm,
    output logic              blank_hours,
    output logic              blank_mins,
    output logic [1:0]        mode,
    output logic              ringing,
    output logic              buzzer
);

    if (RING_TIMEOUT < 1 || RING_TIMEOUT > 255) begin : g_bad_ring_timeout
        $error("RING_TIMEOUT out of range 1..255");
    end
    if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_snooze_min
        $error("SNOOZE_MIN out of range 1..59");
    end

    state_t          state, state_nxt;
    field_t          field, field_nxt;
    logic            blink, blink_nxt;
    logic            acc_c, acc_l, acc_r, acc_u, acc_d;
    logic [HM_W-1:0] time_hm, alarm_step;
    logic            sec_zero, match, match_hist, alarm_rise, snooze_fire, trigger, timeout;
    logic [7:0]      ring_cnt;
    logic            adj_nxt;
    logic            time_en_nxt, disp_alarm_nxt, ringing_nxt, buzzer_nxt;
    logic            blank_hours_nxt, blank_mins_nxt;
    logic            c_up_min_nxt, c_up_hour_nxt, c_down_min_nxt, c_down_hour_nxt;

    // Only the highest-priority coincident button survives.
    assign acc_c = btn_c;
    assign acc_l = btn_l & ~btn_c;
    assign acc_r = btn_r & ~btn_c & ~btn_l;
    assign acc_u = btn_u & ~btn_c & ~btn_l & ~btn_r;
    assign acc_d = btn_d & ~btn_c & ~btn_l & ~btn_r & ~btn_u;

    assign time_hm    = time_bcd[HM_LSB +: HM_W];
    assign sec_zero   = (time_bcd[SEC_W-1:0] == '0);
    assign match      = sec_zero && (time_hm == alarm_bcd);
    assign alarm_rise = match && !match_hist && (state == ST_CLOCK) && alarm_arm;
    assign trigger    = alarm_rise || snooze_fire;
    assign timeout    = tick_1hz && (ring_cnt == 8'(RING_TIMEOUT - 1));

    bcd_hm_step u_alarm_step (
        .hm       (alarm_bcd),
        .field    (field),
        .up       (acc_u),
        .carry_en (1'b0),
        .hm_next  (alarm_step)
    );

`ifdef SNOOZE_EN
    logic [HM_W-1:0] snooze_hm, snooze_step;
    logic [5:0]      snz_cnt;
    logic            snooze_pend, snooze_match, snooze_hist;

    assign snooze_match = snooze_pend && sec_zero && (time_hm == snooze_hm);
    assign snooze_fire  = snooze_match && !snooze_hist && (state == ST_CLOCK) && alarm_arm;

    bcd_hm_step u_snooze_step (
        .hm       (snooze_hm),
        .field    (FIELD_MINS),
        .up       (1'b1),
        .carry_en (1'b1),
        .hm_next  (snooze_step)
    );
`else
    assign snooze_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_CLOCK;
            field       <= FIELD_HOURS;
            blink       <= 1'b0;
            mode        <= MODE_CLOCK;
            time_en     <= 1'b1;
            disp_alarm  <= 1'b0;
            ringing     <= 1'b0;
            buzzer      <= 1'b0;
            blank_hours <= 1'b0;
            blank_mins  <= 1'b0;
            c_up_min    <= 1'b0;
            c_up_hour   <= 1'b0;
            c_down_min  <= 1'b0;
            c_down_hour <= 1'b0;
        end else begin
            state       <= state_nxt;
            field       <= field_nxt;
            blink       <= blink_nxt;
            mode        <= state_mode(state_nxt);
            time_en     <= time_en_nxt;
            disp_alarm  <= disp_alarm_nxt;
            ringing     <= ringing_nxt;
            buzzer      <= buzzer_nxt;
            blank_hours <= blank_hours_nxt;
            blank_mins  <= blank_mins_nxt;
            c_up_min    <= c_up_min_nxt;
            c_up_hour   <= c_up_hour_nxt;
            c_down_min  <= c_down_min_nxt;
            c_down_hour <= c_down_hour_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLOCK: begin
                if (trigger)    state_nxt = ST_RINGING;
                else if (acc_c) state_nxt = ST_ADJ_TIME;
            end
            ST_ADJ_TIME:  if (acc_c) state_nxt = ST_ADJ_ALARM;
            ST_ADJ_ALARM: if (acc_c) state_nxt = ST_CLOCK;
            ST_RINGING: begin
                if (acc_c || !alarm_arm || timeout) state_nxt = ST_CLOCK;
`ifdef SNOOZE_EN
                else if (acc_u)                     state_nxt = ST_SNOOZE_CALC;
`endif
            end
`ifdef SNOOZE_EN
            ST_SNOOZE_CALC: if (snz_cnt == 6'd1) state_nxt = ST_CLOCK;
`endif
            default: state_nxt = ST_CLOCK;
        endcase
    end

    // Outputs are computed from the next state so they land in the same cycle as mode.
    always_comb begin
        adj_nxt = (state_nxt == ST_ADJ_TIME) || (state_nxt == ST_ADJ_ALARM);
        field_nxt = field;
        if (state == ST_ADJ_TIME || state == ST_ADJ_ALARM) begin
            if (acc_l)      field_nxt = FIELD_HOURS;
            else if (acc_r) field_nxt = FIELD_MINS;
        end
        if (adj_nxt && state_nxt != state) field_nxt = FIELD_HOURS;
        blink_nxt = 1'b0;
        if (adj_nxt && state_nxt == state) blink_nxt = blink ^ tick_1hz;
        time_en_nxt     = (state_nxt != ST_ADJ_TIME);
        disp_alarm_nxt  = (state_nxt == ST_ADJ_ALARM);
        ringing_nxt     = (state_nxt == ST_RINGING);
        buzzer_nxt      = 1'b0;
        if (ringing_nxt && state == ST_RINGING) buzzer_nxt = buzzer ^ tick_1hz;
        blank_hours_nxt = adj_nxt && blink_nxt && (field_nxt == FIELD_HOURS);
        blank_mins_nxt  = adj_nxt && blink_nxt && (field_nxt == FIELD_MINS);
        c_up_min_nxt    = (state == ST_ADJ_TIME) && acc_u && (field == FIELD_MINS);
        c_up_hour_nxt   = (state == ST_ADJ_TIME) && acc_u && (field == FIELD_HOURS);
        c_down_min_nxt  = (state == ST_ADJ_TIME) && acc_d && (field == FIELD_MINS);
        c_down_hour_nxt = (state == ST_ADJ_TIME) && acc_d && (field == FIELD_HOURS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_bcd  <= '0;
            ring_cnt   <= 8'd0;
            match_hist <= 1'b0;
        end else begin
            match_hist <= match;
            if (state == ST_ADJ_ALARM && (acc_u || acc_d)) alarm_bcd <= alarm_step;
            if (trigger)                              ring_cnt <= 8'd0;
            else if (state == ST_RINGING && tick_1hz) ring_cnt <= ring_cnt + 8'd1;
        end
    end

`ifdef SNOOZE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snooze_hm   <= '0;
            snz_cnt     <= 6'd0;
            snooze_pend <= 1'b0;
            snooze_hist <= 1'b0;
        end else begin
            snooze_hist <= snooze_match;
            if (state == ST_RINGING && state_nxt == ST_SNOOZE_CALC) begin
                snooze_hm <= time_hm;
                snz_cnt   <= 6'(SNOOZE_MIN);
            end else if (state == ST_SNOOZE_CALC) begin
                snooze_hm <= snooze_step;
                snz_cnt   <= snz_cnt - 6'd1;
            end
            if (state == ST_SNOOZE_CALC && state_nxt == ST_CLOCK) snooze_pend <= 1'b1;
            else if (trigger || (state == ST_RINGING && acc_c))   snooze_pend <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// tb/tb_alarm_mode_ctrl.sv - directed self-checking bench for alarm_mode_ctrl
module tb_alarm_mode_ctrl;

    logic        clk = 1'b0;
    logic        reset, tick_1hz, btn_c, btn_u, btn_d, btn_l, btn_r, alarm_arm;
    logic [19:0] time_bcd;
    logic        time_en, c_up_min, c_up_hour, c_down_min, c_down_hour;
    logic [12:0] alarm_bcd;
    logic        disp_alarm, blank_hours, blank_mins, ringing, buzzer;
    logic [1:0]  mode;
    int          errors = 0;
    int          checks = 0;

    localparam logic [4:0] B_C = 5'b10000, B_L = 5'b01000, B_R = 5'b00100,
                           B_U = 5'b00010, B_D = 5'b00001;

    always #5 clk = ~clk;

    alarm_mode_ctrl dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .alarm_arm(alarm_arm), .time_bcd(time_bcd), .time_en(time_en),
        .c_up_min(c_up_min), .c_up_hour(c_up_hour), .c_down_min(c_down_min), .c_down_hour(c_down_hour),
        .alarm_bcd(alarm_bcd), .disp_alarm(disp_alarm), .blank_hours(blank_hours), .blank_mins(blank_mins),
        .mode(mode), .ringing(ringing), .buzzer(buzzer)
    );

    function automatic logic [12:0] hm(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [19:0] tbcd(input int h, input int m, input int s);
        return {hm(h, m), 3'(s / 10), 4'(s % 10)};
    endfunction

    task automatic press(input logic [4:0] b);
        {btn_c, btn_l, btn_r, btn_u, btn_d} = b;
        @(negedge clk);
        {btn_c, btn_l, btn_r, btn_u, btn_d} = 5'b0;
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick_1hz = 0; alarm_arm = 0; time_bcd = tbcd(12, 0, 1);
        {btn_c, btn_l, btn_r, btn_u, btn_d} = 5'b0;
        repeat (2) @(negedge clk);
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", mode); end
        checks++; if (alarm_bcd !== 13'd0) begin errors++; $display("FAIL reset_alarm: got %h want 0", alarm_bcd); end
        checks++; if (time_en !== 1'b1) begin errors++; $display("FAIL reset_time_en: got %b want 1", time_en); end
        checks++; if ({disp_alarm, ringing, buzzer, blank_hours, blank_mins, c_up_min, c_up_hour, c_down_min, c_down_hour} !== 9'd0)
            begin errors++; $display("FAIL reset_flags: got %b want 0", {disp_alarm, ringing, buzzer, blank_hours, blank_mins, c_up_min, c_up_hour, c_down_min, c_down_hour}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_adj_time();
        int n_up, n_other;
        press(B_C);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL adj_time_mode: got %0d want 1", mode); end
        checks++; if (time_en !== 1'b0) begin errors++; $display("FAIL adj_time_en: got %b want 0", time_en); end
        press(B_R);
        press(B_U);
        n_up = 0; n_other = 0;
        for (int i = 0; i < 4; i++) begin
            n_up += int'(c_up_min); n_other += int'(c_up_hour) + int'(c_down_min) + int'(c_down_hour);
            @(negedge clk);
        end
        checks++; if (n_up != 1 || n_other != 0) begin errors++; $display("FAIL adj_up_min_pulse: got up=%0d other=%0d want 1/0", n_up, n_other); end
        press(B_L);
        press(B_D);
        n_up = 0; n_other = 0;
        for (int i = 0; i < 4; i++) begin
            n_up += int'(c_down_hour); n_other += int'(c_up_hour) + int'(c_down_min) + int'(c_up_min);
            @(negedge clk);
        end
        checks++; if (n_up != 1 || n_other != 0) begin errors++; $display("FAIL adj_down_hour_pulse: got dn=%0d other=%0d want 1/0", n_up, n_other); end
    endtask

    task automatic test_back_to_back();
        int n;
        press(B_C | B_U);
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL b2b_mode: got %0d want 2", mode); end
        n = 0;
        for (int i = 0; i < 3; i++) begin
            n += int'(c_up_min) + int'(c_up_hour) + int'(c_down_min) + int'(c_down_hour);
            @(negedge clk);
        end
        checks++; if (n != 0) begin errors++; $display("FAIL b2b_no_pulse: got %0d want 0", n); end
    endtask

    task automatic test_adj_alarm();
        checks++; if (disp_alarm !== 1'b1 || time_en !== 1'b1) begin errors++; $display("FAIL alarm_disp_en: got %b%b want 11", disp_alarm, time_en); end
        tick();
        checks++; if (blank_hours !== 1'b1 || blank_mins !== 1'b0) begin errors++; $display("FAIL blink_on: got %b%b want 10", blank_hours, blank_mins); end
        tick();
        checks++; if (blank_hours !== 1'b0) begin errors++; $display("FAIL blink_off: got %b want 0", blank_hours); end
        press(B_D);
        checks++; if (alarm_bcd !== hm(23, 0)) begin errors++; $display("FAIL alarm_hour_wrap: got %h want %h", alarm_bcd, hm(23, 0)); end
        press(B_R);
        press(B_D);
        checks++; if (alarm_bcd !== hm(23, 59)) begin errors++; $display("FAIL alarm_min_down_wrap: got %h want %h", alarm_bcd, hm(23, 59)); end
        press(B_U);
        checks++; if (alarm_bcd !== hm(23, 0)) begin errors++; $display("FAIL alarm_min_up_wrap: got %h want %h", alarm_bcd, hm(23, 0)); end
        press(B_L);
        repeat (8) press(B_U);
        press(B_R);
        repeat (30) press(B_U);
        checks++; if (alarm_bcd !== hm(7, 30)) begin errors++; $display("FAIL alarm_0730: got %h want %h", alarm_bcd, hm(7, 30)); end
        press(B_C);
        checks++; if (mode !== 2'd0 || disp_alarm !== 1'b0) begin errors++; $display("FAIL alarm_exit: got mode=%0d disp=%b want 0/0", mode, disp_alarm); end
    endtask

    task automatic test_ring_timeout();
        time_bcd = tbcd(7, 29, 59); alarm_arm = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL pre_match_mode: got %0d want 0", mode); end
        time_bcd = tbcd(7, 30, 0);
        @(negedge clk);
        checks++; if (mode !== 2'd3 || ringing !== 1'b1 || buzzer !== 1'b0) begin errors++; $display("FAIL ring_start: got mode=%0d ring=%b buz=%b want 3/1/0", mode, ringing, buzzer); end
        tick();
        checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL buzzer_t1: got %b want 1", buzzer); end
        tick();
        checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL buzzer_t2: got %b want 0", buzzer); end
        repeat (57) tick();
        checks++; if (mode !== 2'd3 || buzzer !== 1'b1) begin errors++; $display("FAIL ring_t59: got mode=%0d buz=%b want 3/1", mode, buzzer); end
        tick();
        checks++; if (mode !== 2'd0 || buzzer !== 1'b0 || ringing !== 1'b0) begin errors++; $display("FAIL ring_t60: got mode=%0d buz=%b ring=%b want 0/0/0", mode, buzzer, ringing); end
        repeat (5) tick();
        time_bcd = tbcd(7, 30, 7);
        repeat (3) @(negedge clk);
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL no_retrigger: got %0d want 0", mode); end
    endtask

    task automatic test_ring_cancel();
        time_bcd = tbcd(7, 29, 59); @(negedge clk);
        time_bcd = tbcd(7, 30, 0);  @(negedge clk);
        tick();
        checks++; if (mode !== 2'd3 || buzzer !== 1'b1) begin errors++; $display("FAIL cancel_ringing: got mode=%0d buz=%b want 3/1", mode, buzzer); end
        press(B_C);
        checks++; if (mode !== 2'd0 || buzzer !== 1'b0) begin errors++; $display("FAIL cancel_btn_c: got mode=%0d buz=%b want 0/0", mode, buzzer); end
        time_bcd = tbcd(7, 29, 59); @(negedge clk);
        time_bcd = tbcd(7, 30, 0);  @(negedge clk);
        alarm_arm = 1'b0;
        @(negedge clk);
        checks++; if (mode !== 2'd0 || ringing !== 1'b0) begin errors++; $display("FAIL disarm_exit: got mode=%0d ring=%b want 0/0", mode, ringing); end
        alarm_arm = 1'b1;
        time_bcd = tbcd(7, 29, 59); @(negedge clk);
        press(B_C);
        time_bcd = tbcd(7, 30, 0);
        repeat (2) @(negedge clk);
        press(B_C);
        press(B_C);
        repeat (2) @(negedge clk);
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL lost_match: got %0d want 0", mode); end
    endtask

    task automatic test_reset_mid();
        int n;
        time_bcd = tbcd(12, 0, 1);
        press(B_C);
        btn_u = 1'b1;
        @(negedge clk);
        btn_u = 1'b0;
        checks++; if (c_up_hour !== 1'b1) begin errors++; $display("FAIL inflight_pulse: got %b want 1", c_up_hour); end
        #2 reset = 1'b1;
        #1;
        checks++; if (c_up_hour !== 1'b0 || mode !== 2'd0 || time_en !== 1'b1 || alarm_bcd !== 13'd0 || disp_alarm !== 1'b0)
            begin errors++; $display("FAIL mid_reset: got up_h=%b mode=%0d en=%b alarm=%h disp=%b want 0/0/1/0/0", c_up_hour, mode, time_en, alarm_bcd, disp_alarm); end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            n += int'(c_up_min) + int'(c_up_hour) + int'(c_down_min) + int'(c_down_hour);
            @(negedge clk);
        end
        checks++; if (n != 0 || mode !== 2'd0) begin errors++; $display("FAIL post_reset_quiet: got pulses=%0d mode=%0d want 0/0", n, mode); end
    endtask

`ifdef SNOOZE_EN
    task automatic test_snooze();
        press(B_C); press(B_C);
        press(B_D); press(B_R); press(B_D); press(B_D);
        checks++; if (alarm_bcd !== hm(23, 58)) begin errors++; $display("FAIL snooze_alarm_set: got %h want %h", alarm_bcd, hm(23, 58)); end
        press(B_C);
        time_bcd = tbcd(23, 57, 59); @(negedge clk);
        time_bcd = tbcd(23, 58, 0);  @(negedge clk);
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL snooze_first_ring: got %0d want 3", mode); end
        press(B_U);
        repeat (8) @(negedge clk);
        checks++; if (mode !== 2'd0 || ringing !== 1'b0) begin errors++; $display("FAIL snooze_calc_done: got mode=%0d ring=%b want 0/0", mode, ringing); end
        time_bcd = tbcd(0, 2, 59); @(negedge clk);
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL snooze_early: got %0d want 0", mode); end
        time_bcd = tbcd(0, 3, 0); @(negedge clk);
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL snooze_refire: got %0d want 3", mode); end
    endtask
`endif

    initial begin
        test_reset();
        test_adj_time();
        test_back_to_back();
        test_adj_alarm();
        test_ring_timeout();
        test_ring_cancel();
        test_reset_mid();
`ifdef SNOOZE_EN
        test_snooze();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_mode_ctrl.md
Name: alarm_mode_ctrl

Overview:
Mode controller and alarm scheduler for the digital alarm clock.
- Sequences the H:M:S counter: enables and freezes it, and issues up/down adjust pulses.
- Owns the alarm time registers and compares them against the running time.
- Drives the ringing output and selects whether the display mux shows the time or the alarm.
- Sits between the debounced push-buttons and the time counter / display path.

Parameters:
RING_TIMEOUT, 60, seconds of ringing before auto-silence (1..255)
SNOOZE_MIN, 5, snooze interval in minutes (1..59); used only with SNOOZE_EN

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick_1hz  in  1  single-cycle pulse once per second, synchronous to clk
btn_c, btn_u, btn_d, btn_l, btn_r  in  1 each  debounced single-cycle button pulses
alarm_arm  in  1  level switch; 1 = alarm armed
time_bcd  in  20  {hour_tens[1:0], hour_units[3:0], min_tens[2:0], min_units[3:0], sec_tens[2:0], sec_units[3:0]}
time_en  out  1  counter enable
c_up_min, c_up_hour, c_down_min, c_down_hour  out  1 each  single-cycle adjust pulses to the counter
alarm_bcd  out  13  {hour_tens[1:0], hour_units, min_tens[2:0], min_units}
disp_alarm  out  1  1 = display shows alarm_bcd
blank_hours, blank_mins  out  1 each  blink-blank request for the selected field
mode  out  2  0 CLOCK, 1 ADJ_TIME, 2 ADJ_ALARM, 3 RINGING
ringing  out  1  high while in RINGING
buzzer  out  1  toggles on each tick_1hz while ringing; 0 otherwise

Behaviour:
- Reset (async, active-high) clears all registers:
  - mode = CLOCK, field = HOURS, alarm_bcd = 00:00, time_en = 1, all pulses 0.
  - buzzer, ringing, disp_alarm, blank_* = 0; ring counter = 0; match history = 0.
- All outputs are registered.
- Button priority when pulses coincide: btn_c > btn_l > btn_r > btn_u > btn_d. Only the highest is acted on; the rest are dropped.
- CLOCK:
  - time_en = 1.
  - btn_c -> ADJ_TIME with field = HOURS.
  - Other buttons are ignored.
- ADJ_TIME:
  - time_en = 0.
  - btn_l sets field = HOURS; btn_r sets field = MINS.
  - btn_u/btn_d produce exactly one c_up_*/c_down_* pulse for the selected field, one cycle after the button.
  - btn_c -> ADJ_ALARM with field = HOURS.
- ADJ_ALARM:
  - time_en = 1; disp_alarm = 1.
  - btn_u/btn_d step the alarm field in BCD: hours wrap 23<->00, minutes wrap 59<->00, no carry between fields. Updated value is visible on alarm_bcd the next cycle.
  - btn_c -> CLOCK.
- Blink (adjust modes only):
  - A blink flag toggles on each tick_1hz.
  - blank_hours = flag when field = HOURS; blank_mins = flag when field = MINS.
  - Both are 0 in CLOCK and RINGING.
- Alarm match:
  - match = (time H:M == alarm H:M) && time seconds == 00.
  - The trigger is the rising edge of match (registered history), taken only when mode = CLOCK and alarm_arm = 1.
  - Trigger -> RINGING; ring counter cleared.
  - A match arising in any other mode is lost. It does not re-fire within the same minute.
- RINGING:
  - time_en = 1; ringing = 1.
  - buzzer toggles on tick_1hz; ring counter increments on tick_1hz.
  - btn_c, or the counter reaching RING_TIMEOUT -> CLOCK with buzzer = 0.
  - If alarm_arm drops, return to CLOCK on the next cycle.
  - Other buttons: see SNOOZE_EN.
- Reset mid-operation: any in-flight adjust pulse is cleared and no pulse is emitted after reset.

Optional Feature:
SNOOZE_EN.
- Defined:
  - btn_u in RINGING -> SNOOZE_CALC.
  - SNOOZE_CALC copies the current H:M into snooze registers, then performs SNOOZE_MIN single-cycle minute increments with carry into hours (23:59 -> 00:00). It then enters CLOCK with snooze_pend = 1.
  - The match logic also fires on snooze H:M (same rising-edge/seconds rule); firing clears snooze_pend.
  - btn_c in RINGING clears snooze_pend.
- Undefined: btn_u in RINGING is ignored; there are no snooze registers and no SNOOZE_CALC state.

Decomposition:
- Package alarm_pkg: mode encoding, field encoding (HOURS/MINS), BCD field widths, time_bcd slice offsets.
- Sub-module bcd_hm_step:
  - Combinational up/down step of a 13-bit H:M BCD value.
  - Inputs: field select, direction, carry_en.
  - Used for alarm adjust (carry_en = 0) and snooze increment (carry_en = 1).

Test Plan:
- Reset -> mode 0, alarm_bcd 00:00, time_en 1. Apply btn_c, btn_r, btn_u -> exactly one c_up_min pulse, time_en 0.
- ADJ_ALARM hours: btn_d from 00 -> 23. Minutes at 59 with btn_u -> 00, hours unchanged.
- Alarm 07:30, armed, time_bcd steps 07:29:59 -> 07:30:00 -> RINGING one cycle later; buzzer toggles each tick.
- Ringing with no button -> CLOCK after exactly 60 ticks. Time then stays 07:30:xx with no re-trigger.
- Same-cycle btn_c + btn_u in ADJ_TIME -> mode advances to ADJ_ALARM, no c_up pulse. Reset asserted mid-adjust -> all outputs at reset values.
- SNOOZE_EN: ring at 23:58, btn_u -> snooze target 00:03. Ring re-fires at 00:03:00.
